// File: rtl/acc16_flag_unit.sv
// rtl/acc16_flag_unit.sv - registered accumulate/flag stage around a 16-bit ripple-carry adder
// Optional feature macro: STICKY_FLAGS_EN (sticky carry/overflow status bank).

module str_rca_16adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        sign,
  output logic        zero,
  output logic        carry,
  output logic        parity,
  output logic        overflow
);
  logic [16:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign c[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign sign     = c[15];
  assign zero     = ~|c;
  assign carry    = cy[16];
  assign parity   = ~^c;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = cy[16] ^ cy[15];
endmodule

module acc16_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_sign,
  output logic        out_zero,
  output logic        out_carry,
  output logic        out_parity,
  output logic        out_overflow,
  output logic [15:0] acc,
  output logic        sticky_carry,
  output logic        sticky_ovf,
  output logic [7:0]  op_count
);
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_TEST = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] opnd_q;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] sum;
  logic        f_sign;
  logic        f_zero;
  logic        f_carry;
  logic        f_parity;
  logic        f_overflow;

  assign in_ready = (state == IDLE);

  always_comb begin
    add_a = 16'h0000;
    add_b = 16'h0000;
    case (op_q)
      OP_LOAD: begin
        add_a = opnd_q;
        add_b = 16'h0000;
      end
      OP_ADD, OP_TEST: begin
        add_a = acc;
        add_b = opnd_q;
      end
      default: begin
        add_a = 16'h0000;
        add_b = 16'h0000;
      end
    endcase
  end

  str_rca_16adder u_adder (
    .a        (add_a),
    .b        (add_b),
    .c        (sum),
    .sign     (f_sign),
    .zero     (f_zero),
    .carry    (f_carry),
    .parity   (f_parity),
    .overflow (f_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_LOAD;
      opnd_q       <= 16'h0000;
      acc          <= 16'h0000;
      out_result   <= 16'h0000;
      out_sign     <= 1'b0;
      out_zero     <= 1'b0;
      out_carry    <= 1'b0;
      out_parity   <= 1'b0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
      op_count     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            opnd_q <= in_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_result   <= sum;
          out_sign     <= f_sign;
          out_zero     <= f_zero;
          out_carry    <= f_carry;
          out_parity   <= f_parity;
          out_overflow <= f_overflow;
          if (op_q != OP_TEST) begin
            acc <= sum;
          end
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef STICKY_FLAGS_EN
  // Only ADD accumulates status; CLR is the software-visible way to wipe it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
    end else if (state == EXEC) begin
      if (op_q == OP_ADD) begin
        sticky_carry <= sticky_carry | f_carry;
        sticky_ovf   <= sticky_ovf | f_overflow;
      end else if (op_q == OP_CLR) begin
        sticky_carry <= 1'b0;
        sticky_ovf   <= 1'b0;
      end
    end
  end
`else
  assign sticky_carry = 1'b0;
  assign sticky_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_acc16_flag_unit.sv
// tb/tb_acc16_flag_unit.sv - directed self-checking bench for acc16_flag_unit

module tb_acc16_flag_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_sign, out_zero, out_carry, out_parity, out_overflow;
  logic [15:0] acc;
  logic        sticky_carry, sticky_ovf;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;
  bit done = 0;

  logic [15:0] e_acc = 16'h0, e_res = 16'h0;
  logic        e_sign = 0, e_zero = 0, e_carry = 0, e_par = 0, e_ovf = 0;
  logic        e_valid = 0, e_ready = 1, e_sc = 0, e_so = 0;
  logic [7:0]  e_cnt = 8'h0;

  acc16_flag_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sign(out_sign), .out_zero(out_zero),
    .out_carry(out_carry), .out_parity(out_parity), .out_overflow(out_overflow),
    .acc(acc), .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    e_acc = 0; e_res = 0; e_sign = 0; e_zero = 0; e_carry = 0; e_par = 0; e_ovf = 0;
    e_valid = 0; e_ready = 1; e_sc = 0; e_so = 0; e_cnt = 0;
  endtask

  // Result of one operation from the arithmetic definition of the flags.
  task automatic model_exec(input logic [1:0] op, input logic [15:0] data);
    logic [15:0] a, b;
    int s, sa, sb;
    case (op)
      2'b00:   begin a = data;  b = 16'h0; end
      2'b11:   begin a = 16'h0; b = 16'h0; end
      default: begin a = e_acc; b = data;  end
    endcase
    s = int'(a) + int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    e_res   = s[15:0];
    e_carry = (s > 65535);
    e_ovf   = ((sa + sb) > 32767) || ((sa + sb) < -32768);
    e_sign  = (e_res >= 16'h8000);
    e_zero  = (e_res == 16'h0);
    e_par   = (($countones(e_res) % 2) == 0);
    if (op != 2'b10) e_acc = e_res;
`ifdef STICKY_FLAGS_EN
    if (op == 2'b01) begin
      e_sc = e_sc | e_carry;
      e_so = e_so | e_ovf;
    end else if (op == 2'b11) begin
      e_sc = 0;
      e_so = 0;
    end
`endif
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
  task automatic do_op(input logic [1:0] op, input logic [15:0] data, input int hold);
    in_valid = 1; in_op = op; in_data = data;
    @(posedge clk); #1;
    in_valid = 0; e_ready = 0;
    @(posedge clk); #1;
    model_exec(op, data);
    e_valid = 1;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; in_op = 2'b11; in_data = 16'h5a5a;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    e_valid = 0; e_ready = 1; e_cnt = e_cnt + 8'd1;
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("in_ready", in_ready, e_ready);
      chk("out_valid", out_valid, e_valid);
      chk("out_result", out_result, e_res);
      chk("out_sign", out_sign, e_sign);
      chk("out_zero", out_zero, e_zero);
      chk("out_carry", out_carry, e_carry);
      chk("out_parity", out_parity, e_par);
      chk("out_overflow", out_overflow, e_ovf);
      chk("acc", acc, e_acc);
      chk("sticky_carry", sticky_carry, e_sc);
      chk("sticky_ovf", sticky_ovf, e_so);
      chk("op_count", op_count, e_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_model();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    do_op(2'b00, 16'h8fff, 0);
    do_op(2'b01, 16'h8000, 0);
    chk("lit1_result", out_result, 16'h0fff);
    chk("lit1_carry", out_carry, 1);
    chk("lit1_ovf", out_overflow, 1);
    chk("lit1_sign", out_sign, 0);
    chk("lit1_acc", acc, 16'h0fff);
`ifdef STICKY_FLAGS_EN
    chk("lit1_sticky", {sticky_carry, sticky_ovf}, 2'b11);
`else
    chk("lit1_sticky", {sticky_carry, sticky_ovf}, 2'b00);
`endif

    do_op(2'b00, 16'hffff, 1);
    do_op(2'b01, 16'h0001, 0);
    chk("lit2_result", out_result, 16'h0000);
    chk("lit2_flags", {out_zero, out_carry, out_overflow, out_parity}, 4'b1101);
    do_op(2'b11, 16'h1234, 0);
    chk("lit3_clr", {out_result, out_zero}, {16'h0, 1'b1});
    chk("lit3_sticky", {sticky_carry, sticky_ovf}, 2'b00);
    chk("lit3_count", op_count, 8'd5);

    do_op(2'b00, 16'h6ffe, 0);
    do_op(2'b10, 16'h0002, 2);
    chk("lit4_result", out_result, 16'h7000);
    chk("lit4_sign_ovf", {out_sign, out_overflow}, 2'b00);
    chk("lit4_acc", acc, 16'h6ffe);
    do_op(2'b00, 16'haaaa, 0);
    do_op(2'b01, 16'h5555, 0);
    chk("lit5_result", out_result, 16'hffff);
    chk("lit5_flags", {out_sign, out_parity, out_carry}, 3'b110);

    // Backpressure with in_valid pulsing; compare process covers stability.
    do_op(2'b01, 16'h0001, 5);
    chk("lit6_count", op_count, 8'd10);
    do_op(2'b00, 16'h1234, 0);

    // Asynchronous reset while an ADD sits in EXEC.
    in_valid = 1; in_op = 2'b01; in_data = 16'h0101;
    @(posedge clk); #1;
    in_valid = 0; e_ready = 0;
    #2 rst_n = 0;
    reset_model();
    #1;
    chk("arst_acc", acc, 16'h0);
    chk("arst_count", op_count, 8'h0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_result", out_result, 16'h0);
    chk("arst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_count", op_count, 8'h0);
    do_op(2'b00, 16'h0042, 0);
    chk("recover_acc", acc, 16'h0042);

    repeat (2) @(posedge clk);
    #1;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
